uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL: DATA_BITS, 8, data bits per frame, legal range 5..9.
REQ-002 SHALL: OVERSAMPLE, 16, clken ticks per bit, even, 8..32.
REQ-003 SHALL: STOP_BITS, 1, stop bits checked, 1 or 2.
REQ-004 SHALL: FIFO_DEPTH, 4, receive FIFO entries, power of two, 2..64.
REQ-005 SHALL: clk_50m  in  1  sole clock, rising edge.
REQ-006 SHALL: rst  in  1  asynchronous active-high reset.
REQ-007 SHALL: clken  in  1  oversample tick enable, one clk_50m cycle wide.
REQ-008 SHALL: rx  in  1  serial line, asynchronous, idle high.
REQ-009 SHALL: data  out  DATA_BITS  FIFO head word, first-word-fall-through.
REQ-010 SHALL: rdy  out  1  FIFO non-empty.
REQ-011 SHALL: rd  in  1  pop request; ignored when rdy=0.
REQ-012 SHALL: count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-013 SHALL: frame_err, overrun  out  1 each  sticky error flags.
REQ-014 SHALL: err_clr  in  1  clears all sticky flags.

Function
REQ-015 SHALL: rx pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-016 SHALL: the FSM states be IDLE, START, DATA, PARITY (macro only), STOP; it advances only on clken=1 cycles.
REQ-017 SHALL: in IDLE, synchronized rx=0 on a tick -> START, sample counter=0.
REQ-018 SHALL: a bit value be the majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit.
REQ-019 SHALL: START return to IDLE with no push if the majority start value is 1 (glitch rejection).
REQ-020 SHALL: DATA capture DATA_BITS bits LSB first, one bit per OVERSAMPLE ticks.
REQ-021 SHALL: STOP evaluate STOP_BITS stop bits; IDLE is re-entered on the tick after the last stop-bit majority sample, not at bit end, tolerating baud mismatch.
REQ-022 SHALL: any stop bit sampled 0 discard the word, set frame_err, and leave the FIFO unchanged.
REQ-023 SHALL: a valid frame push the word on the cycle IDLE is re-entered.
REQ-024 SHALL: a push while full with no simultaneous pop drop the new word, set overrun, and keep FIFO contents.
REQ-025 SHALL: simultaneous push and pop succeed in any state, including full (count unchanged, no overrun).
REQ-026 SHALL: a pop take effect on the clock edge; data shows the next entry the following cycle.
REQ-027 SHALL: FIFO pointers wrap modulo FIFO_DEPTH; count is exact 0..FIFO_DEPTH.
REQ-028 SHALL: err_clr clear flags on the clock edge; an error event in the same cycle wins (flag stays 1).

Reset
REQ-029 SHALL: rst force FSM=IDLE, counters=0, synchronizer flops=1, FIFO empty, data=0, rdy=0, count=0, frame_err=0, overrun=0, parity_err=0, asynchronously.
REQ-030 SHALL: reset mid-frame abandon the frame with no push; reception resumes at the next falling edge after rst deasserts.

Configuration
REQ-031 SHALL: macro UART_RX_PARITY_EN, when defined, add parameter PARITY_ODD (default 0), the PARITY state after DATA, and output parity_err (1, sticky, cleared by err_clr).
REQ-032 SHALL: with UART_RX_PARITY_EN, a parity mismatch discard the word and set parity_err; without it, no PARITY state and no parity_err port exist.

Verification
REQ-033 SHALL: defaults, clken every cycle, send 8N1 0xA5 -> rdy=1, data=0xA5, count=1 one cycle after the stop-bit middle sample.
REQ-034 SHALL: rx low 4 ticks then high -> no push, FSM back in IDLE, count=0.
REQ-035 SHALL: frame 0x3C with stop bit 0 -> frame_err=1, count=0; err_clr pulse -> frame_err=0.
REQ-036 SHALL: send 0x01..0x05 without rd (depth 4) -> count=4, overrun=1, data=0x01; four pops yield 0x01..0x04.
REQ-037 SHALL: FIFO full, rd asserted on the push cycle of 0x77 -> count stays 4, overrun=0, 0x77 last out.
REQ-038 SHALL: UART_RX_PARITY_EN, PARITY_ODD=0, send 0x01 with parity bit 0 -> parity_err=1, count=0; rst asserted mid-DATA -> all outputs at reset values.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   Oversampling UART receiver feeding a first-word-fall-through receive FIFO.
//   The serial line goes through a two-flop synchronizer. A receive FSM then
//   advances only on clken ticks. Each bit value is the majority of three
//   samples taken around the bit centre. Completed words are pushed into a
//   FIFO with sticky error reporting.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     When defined, this adds parameter PARITY_ODD, a PARITY state after the
//     data bits, and the sticky output parity_err.
//
//   Ports
//     clk_50m    in   sole clock, rising edge
//     rst        in   asynchronous active-high reset
//     clken      in   oversample tick enable, one clk_50m cycle wide
//     rx         in   serial line, asynchronous, idle high
//     data       out  FIFO head word (first-word-fall-through), 0 when empty
//     rdy        out  FIFO non-empty
//     rd         in   pop request, ignored when rdy=0
//     count      out  FIFO occupancy, 0..FIFO_DEPTH
//     frame_err  out  sticky: a stop bit was sampled low
//     overrun    out  sticky: a word arrived while the FIFO was full
//     parity_err out  sticky: parity mismatch (UART_RX_PARITY_EN only)
//     err_clr    in   clears all sticky flags; a same-cycle error event wins
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
`ifdef UART_RX_PARITY_EN
    ,
    parameter int PARITY_ODD = 0
`endif
) (
    input  logic                          clk_50m,
    input  logic                          rst,
    input  logic                          clken,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          data,
    output logic                          rdy,
    input  logic                          rd,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overrun,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err,
`endif
    input  logic                          err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(OVERSAMPLE);

    // Sample points inside a bit, counted in ticks from the bit start.
    localparam int TICK_LO_I   = OVERSAMPLE / 2 - 1;
    localparam int TICK_MID_I  = OVERSAMPLE / 2;
    localparam int TICK_HI_I   = OVERSAMPLE / 2 + 1;
    localparam int TICK_LAST_I = OVERSAMPLE - 1;
    localparam int ONE_I       = 1;
    localparam int BIT_LAST_I  = DATA_BITS - 1;
    localparam int STOP_LAST_I = STOP_BITS - 1;

    localparam logic [CW-1:0] TICK_LO   = TICK_LO_I[CW-1:0];
    localparam logic [CW-1:0] TICK_MID  = TICK_MID_I[CW-1:0];
    localparam logic [CW-1:0] TICK_HI   = TICK_HI_I[CW-1:0];
    localparam logic [CW-1:0] TICK_LAST = TICK_LAST_I[CW-1:0];
    localparam logic [CW-1:0] CNT_ONE   = ONE_I[CW-1:0];
    localparam logic [3:0]    BIT_LAST  = BIT_LAST_I[3:0];
    localparam logic          STOP_LAST = STOP_LAST_I[0];
    localparam logic [AW-1:0] PTR_ONE   = ONE_I[AW-1:0];
    localparam logic [AW:0]   OCC_ONE   = ONE_I[AW:0];
    localparam logic [AW:0]   FULL_CNT  = FIFO_DEPTH[AW:0];
`ifdef UART_RX_PARITY_EN
    localparam logic          PAR_ODD   = PARITY_ODD[0];
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    // Majority vote of the three samples taken around a bit centre.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Even parity of a received word (XOR of all bits).
    function automatic logic even_par(input logic [DATA_BITS-1:0] w);
        return ^w;
    endfunction

    // ---------------------------------------------------------------- signals
    logic                 rx_meta_q, rx_sync_q;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic                 s0_q, s0_d, s1_q, s1_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 maj_s, push_req_s, frame_evt_s, overrun_evt_s;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d, parity_evt_s;
    logic                 parity_err_q, parity_err_d;
`endif

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 rdy_q, rdy_d;
    logic                 frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic                 pop_s, push_ok_s, full_s;

    // Two-flop synchronizer for the asynchronous serial line, idle high.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receive FSM: tick counting, three-point sampling and frame decisions.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        stop_d      = stop_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        shift_d     = shift_q;
        push_req_s  = 1'b0;
        frame_evt_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_evt_s = 1'b0;
`endif
        // Third sample is the live synchronized value at the TICK_HI tick.
        maj_s = maj3(s0_q, s1_q, rx_sync_q);

        if (clken) begin
            if (cnt_q == TICK_LO) begin
                s0_d = rx_sync_q;
            end else if (cnt_q == TICK_MID) begin
                s1_d = rx_sync_q;
            end else begin
                s1_d = s1_q;
            end

            case (state_q)
                IDLE: begin
                    if (!rx_sync_q) begin
                        state_d = START;
                        cnt_d   = '0;
`ifdef UART_RX_PARITY_EN
                        par_bad_d = 1'b0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
                START: begin
                    if (cnt_q == TICK_HI && maj_s) begin
                        // Start bit did not hold low through its centre: glitch.
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TICK_LAST) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        bit_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_q == TICK_HI) begin
                        // LSB first: shift in from the top.
                        shift_d = {maj_s, shift_q[DATA_BITS-1:1]};
                        cnt_d   = cnt_q + CNT_ONE;
                    end else if (cnt_q == TICK_LAST) begin
                        cnt_d = '0;
                        if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                            stop_d = 1'b0;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == TICK_HI) begin
                        par_bad_d    = maj_s != (even_par(shift_q) ^ PAR_ODD);
                        parity_evt_s = maj_s != (even_par(shift_q) ^ PAR_ODD);
                        cnt_d        = cnt_q + CNT_ONE;
                    end else if (cnt_q == TICK_LAST) begin
                        state_d = STOP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
`endif
                STOP: begin
                    if (cnt_q == TICK_HI) begin
                        // Leave right after the decision so a slightly fast
                        // transmitter's next start edge is not missed.
                        if (!maj_s) begin
                            frame_evt_s = 1'b1;
                            state_d     = IDLE;
                            cnt_d       = '0;
                        end else if (stop_q == STOP_LAST) begin
`ifdef UART_RX_PARITY_EN
                            push_req_s = ~par_bad_q;
`else
                            push_req_s = 1'b1;
`endif
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else if (cnt_q == TICK_LAST) begin
                        cnt_d  = '0;
                        stop_d = stop_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Receive FSM state and datapath registers.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            stop_q  <= 1'b0;
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
            shift_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // FIFO control, head-word prefetch and sticky error flags.
    always_comb begin
        pop_s         = rd & rdy_q;
        full_s        = (count_q == FULL_CNT);
        push_ok_s     = push_req_s & (~full_s | pop_s);
        overrun_evt_s = push_req_s & full_s & ~pop_s;

        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + OCC_ONE;
            2'b01:   count_d = count_q - OCC_ONE;
            default: count_d = count_q;
        endcase

        // The incoming word becomes the head when the FIFO is, or is about
        // to become, otherwise empty; it is not in memory yet, so bypass it.
        if (count_d == '0) begin
            data_d = '0;
        end else if (push_ok_s && (count_q == '0 || (count_q == OCC_ONE && pop_s))) begin
            data_d = shift_q;
        end else begin
            data_d = mem_q[rd_ptr_d];
        end
        rdy_d = (count_d != '0);

        frame_err_d = frame_evt_s   | (frame_err_q & ~err_clr);
        overrun_d   = overrun_evt_s | (overrun_q & ~err_clr);
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_evt_s | (parity_err_q & ~err_clr);
`endif
    end

    // FIFO storage; contents are only ever read from occupied slots.
    always_ff @(posedge clk_50m) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // FIFO pointers, occupancy, registered outputs and flags.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_q      <= '0;
            rdy_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_q      <= data_d;
            rdy_q       <= rdy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data      = data_q;
    assign rdy       = rdy_q;
    assign count     = count_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo with default parameters. Frames are
//   built bit by bit from words. A queue-based model of the receive FIFO plus
//   expected sticky flags supplies every expected value.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int DB = 8;
    localparam int OS = 16;
    localparam int FD = 4;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB = 2 + DB + PB;
    // Cycles from the start bit hitting rx to the push edge, with clken every
    // cycle: two synchronizer flops plus the detecting tick, the start/data
    // (/parity) bits, then the stop bit up to its last majority sample.
    localparam int PUSH_LAT = 4 + OS * (1 + DB + PB) + OS / 2 + 1;

    logic       clk_50m = 1'b0;
    logic       rst = 1'b1;
    logic       clken = 1'b1;
    logic       rx = 1'b1;
    logic       rd = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] data;
    logic       rdy;
    logic [2:0] count;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    logic rdy_prev = 1'b0;
    bit half = 1'b0;

    logic [7:0] model_q[$];
    logic exp_ovr = 1'b0;
    logic exp_ferr = 1'b0;

    uart_rx_fifo dut (
        .clk_50m   (clk_50m),
        .rst       (rst),
        .clken     (clken),
        .rx        (rx),
        .data      (data),
        .rdy       (rdy),
        .rd        (rd),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .err_clr   (err_clr)
    );

    always #10 clk_50m = ~clk_50m;

    always @(posedge clk_50m) cyc <= cyc + 1;

    // Remember the cycle of the latest rdy rising edge.
    always @(negedge clk_50m) begin
        if (rdy && !rdy_prev) rise_cyc <= cyc;
        rdy_prev <= rdy;
    end

    // clken every cycle, or every second cycle when half is set.
    initial begin
        forever begin
            @(posedge clk_50m);
            #1;
            if (half) clken = ~clken;
            else clken = 1'b1;
        end
    end

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: time limit reached, wanted finish");
        $fatal(1, "watchdog");
    end

    // Start bit, data LSB first, optional even parity (flippable), stop bit.
    function automatic logic [11:0] build_frame(input logic [7:0] w, input logic stop_bad,
                                                input logic par_flip);
        logic [11:0] f;
        f = 12'hFFF;
        f[0] = 1'b0;
        f[8:1] = w;
        if (PB == 1) begin
            f[9]  = (^w) ^ par_flip;
            f[10] = ~stop_bad;
        end else begin
            f[9] = ~stop_bad;
        end
        return f;
    endfunction

    // Drives one frame at cpb clock cycles per bit, then an idle gap.
    // Called and returns at #1 after a rising edge.
    task automatic send_frame(input logic [11:0] f, input int cpb);
        start_cyc = cyc;
        for (int i = 0; i < NB; i++) begin
            rx = f[i];
            repeat (cpb) @(posedge clk_50m);
            #1;
        end
        rx = 1'b1;
        repeat (24) @(posedge clk_50m);
        #1;
    endtask

    // Model update for a frame that arrived with no concurrent pop.
    task automatic model_frame(input logic [7:0] w, input logic stop_bad);
        if (stop_bad) exp_ferr = 1'b1;
        else if (model_q.size() < FD) model_q.push_back(w);
        else exp_ovr = 1'b1;
    endtask

    task automatic pop_word();
        rd = 1'b1;
        @(posedge clk_50m);
        #1;
        rd = 1'b0;
        if (model_q.size() > 0) void'(model_q.pop_front());
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(posedge clk_50m);
        #1;
        err_clr = 1'b0;
        exp_ovr = 1'b0;
        exp_ferr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk_50m);
        #1;
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b want=0", rdy); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", data); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", frame_err); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b want=0", overrun); end
        rst = 1'b0;
        @(posedge clk_50m);
        #1;
    endtask

    task automatic test_basic();
        send_frame(build_frame(8'hA5, 1'b0, 1'b0), OS);
        model_frame(8'hA5, 1'b0);
        total++; if (rise_cyc - start_cyc !== PUSH_LAT) begin bad++;
            $display("FAIL basic_latency got=%0d want=%0d", rise_cyc - start_cyc, PUSH_LAT); end
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL basic_rdy got=%b want=1", rdy); end
        total++; if (data !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h want=a5", data); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL basic_count got=%0d want=1", count); end
        pop_word();
        total++; if (count !== 3'd0 || rdy !== 1'b0) begin bad++;
            $display("FAIL basic_pop count=%0d rdy=%b want 0/0", count, rdy); end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (4) @(posedge clk_50m);
        #1;
        rx = 1'b1;
        repeat (30) @(posedge clk_50m);
        #1;
        total++; if (count !== 3'd0 || rdy !== 1'b0) begin bad++;
            $display("FAIL glitch_nopush count=%0d rdy=%b want 0/0", count, rdy); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL glitch_ferr got=%b want=0", frame_err); end
        send_frame(build_frame(8'h5A, 1'b0, 1'b0), OS);
        model_frame(8'h5A, 1'b0);
        total++; if (data !== 8'h5A || count !== 3'd1) begin bad++;
            $display("FAIL glitch_next data=%h count=%0d want 5a/1", data, count); end
        pop_word();
    endtask

    task automatic test_frame_err();
        send_frame(build_frame(8'h3C, 1'b1, 1'b0), OS);
        model_frame(8'h3C, 1'b1);
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_set got=%b want=1", frame_err); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL ferr_count got=%0d want=0", count); end
        clear_errors();
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ferr_clr got=%b want=0", frame_err); end
        // err_clr on the same edge as a new frame error: the error wins.
        fork
            send_frame(build_frame(8'hC3, 1'b1, 1'b0), OS);
            begin
                repeat (PUSH_LAT - 1) @(posedge clk_50m);
                #1;
                err_clr = 1'b1;
                @(posedge clk_50m);
                #1;
                err_clr = 1'b0;
                total++; if (frame_err !== 1'b1) begin bad++;
                    $display("FAIL ferr_priority got=%b want=1", frame_err); end
            end
        join
        clear_errors();
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) begin
            send_frame(build_frame(8'(i), 1'b0, 1'b0), OS);
            model_frame(8'(i), 1'b0);
        end
        total++; if (int'(count) !== model_q.size()) begin bad++;
            $display("FAIL ovr_count got=%0d want=%0d", count, model_q.size()); end
        total++; if (overrun !== exp_ovr) begin bad++; $display("FAIL ovr_flag got=%b want=%b", overrun, exp_ovr); end
        total++; if (data !== model_q[0]) begin bad++; $display("FAIL ovr_head got=%h want=%h", data, model_q[0]); end
        for (int i = 0; i < FD; i++) begin
            total++; if (data !== model_q[0]) begin bad++;
                $display("FAIL ovr_pop%0d got=%h want=%h", i, data, model_q[0]); end
            pop_word();
        end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL ovr_empty got=%0d want=0", count); end
        clear_errors();
    endtask

    task automatic test_simultaneous();
        for (int i = 1; i <= FD; i++) begin
            send_frame(build_frame(8'(i), 1'b0, 1'b0), OS);
            model_frame(8'(i), 1'b0);
        end
        fork
            send_frame(build_frame(8'h77, 1'b0, 1'b0), OS);
            begin
                repeat (PUSH_LAT - 1) @(posedge clk_50m);
                #1;
                rd = 1'b1;
                @(posedge clk_50m);
                #1;
                rd = 1'b0;
            end
        join
        void'(model_q.pop_front());
        model_q.push_back(8'h77);
        total++; if (count !== 3'd4) begin bad++; $display("FAIL simul_count got=%0d want=4", count); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL simul_ovr got=%b want=0", overrun); end
        for (int i = 0; i < FD; i++) begin
            total++; if (data !== model_q[0]) begin bad++;
                $display("FAIL simul_pop%0d got=%h want=%h", i, data, model_q[0]); end
            pop_word();
        end
    endtask

    task automatic test_clken_half();
        half = 1'b1;
        send_frame(build_frame(8'h96, 1'b0, 1'b0), 2 * OS);
        model_frame(8'h96, 1'b0);
        half = 1'b0;
        total++; if (data !== 8'h96 || count !== 3'd1) begin bad++;
            $display("FAIL half_rate data=%h count=%0d want 96/1", data, count); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL half_ferr got=%b want=0", frame_err); end
        pop_word();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        send_frame(build_frame(8'h01, 1'b0, 1'b1), OS);
        total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL par_set got=%b want=1", parity_err); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL par_count got=%0d want=0", count); end
        clear_errors();
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_clr got=%b want=0", parity_err); end
    endtask
`endif

    task automatic test_random();
        logic [7:0] w;
        logic sb;
        int k;
        for (int n = 0; n < 20; n++) begin
            w = 8'($urandom);
            sb = ($urandom_range(0, 3) == 0);
            send_frame(build_frame(w, sb, 1'b0), OS);
            model_frame(w, sb);
            total++; if (int'(count) !== model_q.size()) begin bad++;
                $display("FAIL rnd_count n=%0d got=%0d want=%0d", n, count, model_q.size()); end
            total++; if (overrun !== exp_ovr || frame_err !== exp_ferr) begin bad++;
                $display("FAIL rnd_flags n=%0d ovr=%b ferr=%b want %b/%b", n, overrun, frame_err, exp_ovr, exp_ferr); end
            k = $urandom_range(0, 2);
            for (int p = 0; p < k; p++) begin
                if (model_q.size() > 0) begin
                    total++; if (data !== model_q[0]) begin bad++;
                        $display("FAIL rnd_data n=%0d got=%h want=%h", n, data, model_q[0]); end
                    pop_word();
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        send_frame(build_frame(8'h42, 1'b0, 1'b0), OS);
        send_frame(build_frame(8'h24, 1'b1, 1'b0), OS);
        fork
            send_frame(build_frame(8'h99, 1'b0, 1'b0), OS);
            begin
                repeat (60) @(posedge clk_50m);
                #1;
                rst = 1'b1;
                #1;
                total++; if (rdy !== 1'b0 || count !== 3'd0 || data !== 8'h00) begin bad++;
                    $display("FAIL midrst_fifo rdy=%b count=%0d data=%h want 0/0/00", rdy, count, data); end
                total++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin bad++;
                    $display("FAIL midrst_flags ferr=%b ovr=%b want 0/0", frame_err, overrun); end
`ifdef UART_RX_PARITY_EN
                total++; if (parity_err !== 1'b0) begin bad++;
                    $display("FAIL midrst_par got=%b want=0", parity_err); end
`endif
            end
        join
        rst = 1'b0;
        model_q.delete();
        exp_ovr = 1'b0;
        exp_ferr = 1'b0;
        @(posedge clk_50m);
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL midrst_nopush got=%0d want=0", count); end
        send_frame(build_frame(8'h3E, 1'b0, 1'b0), OS);
        model_frame(8'h3E, 1'b0);
        total++; if (data !== 8'h3E || count !== 3'd1) begin bad++;
            $display("FAIL midrst_resume data=%h count=%0d want 3e/1", data, count); end
        pop_word();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_simultaneous();
        test_clken_half();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
